pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Parametrised hazard, forwarding and stall-arbitration controller for the 5-stage RISC-V pipeline. It replaces the fixed single-cycle hazard logic with support for variable-latency data memory (ready handshake with timeout trap) and a multi-cycle execute unit (busy stall). It also provides saturating stall/redirect performance counters. It sits beside the datapath and drives the enables and clears of the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB registers, plus the E-stage operand-forward muxes.

## Interface
Parameters:
- REG_ADDR_W, 5: register index width.
- CNT_W, 32: performance counter width.
- MAX_MEM_WAIT, 64: consecutive not-ready memory cycles before trap (≥1).

Ports (the clock is `clk`; reset is `rst`, synchronous, active-high):
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- Rs1D, Rs2D  in  REG_ADDR_W  source registers in D
- Rs1E, Rs2E, RdE  in  REG_ADDR_W  source/dest registers in E
- RdM, RdW  in  REG_ADDR_W  dest registers in M, W
- regWriteM, regWriteW  in  1  writeback enables in M, W
- resultSrcE  in  2  result select in E; 2'b01 = load
- PCSrcE  in  2  PC select from branch controller; nonzero = redirect
- memReqM  in  1  load/store present in M
- memReadyM  in  1  data memory completes access this cycle
- exBusyE  in  1  multi-cycle execute unit not finished
- stallF, stallD, stallE, stallM  out  1  hold PC / IF/ID / ID/EX / EX/MEM
- flushD, flushE, flushM, flushW  out  1  clear IF/ID / ID/EX / EX/MEM / MEM/WB
- forwardAE, forwardBE  out  2  00 register file, 01 resultW, 10 ALUResultM
- memTimeout  out  1  sticky memory timeout trap
- stallCount, redirectCount  out  CNT_W  saturating counters

## Operation
- Forwarding, combinational, independent of stalls. For A:
  - regWriteM & RdM≠0 & RdM==Rs1E → 10;
  - else regWriteW & RdW≠0 & RdW==Rs1E → 01;
  - else 00.
  - B is identical using Rs2E.
- Control conditions, evaluated in strict priority order; only the highest active one applies:
  1. TRAP state: stallF/D/E/M=1, flushW=1, all other flushes 0.
  2. memStall = memReqM & ~memReadyM: stallF/D/E/M=1, flushW=1.
  3. exBusyE: stallF/D/E=1, flushM=1; PCSrcE ignored.
  4. redirect = PCSrcE≠00: flushD=1, flushE=1, no stalls. This overrides load-use.
  5. loadUse = resultSrcE==01 & RdE≠0 & (RdE==Rs1D | RdE==Rs2D): stallF=1, stallD=1, flushE=1.
  6. Otherwise all stall/flush outputs are 0.
- FSM states RUN, MEM_WAIT, TRAP; a waitCnt register (width clog2(MAX_MEM_WAIT+1)) tracks consecutive not-ready cycles.
  - RUN: on memStall, waitCnt←1 and go to MEM_WAIT; if MAX_MEM_WAIT==1, go to TRAP instead.
  - MEM_WAIT: on memReadyM or ~memReqM, waitCnt←0 and go to RUN. Otherwise waitCnt←waitCnt+1, and when waitCnt+1==MAX_MEM_WAIT go to TRAP.
  - TRAP: memTimeout=1; held until rst.
- stallCount increments on every cycle with stallF=1. redirectCount increments on every cycle where condition 4 applies. Both saturate at all-ones and never wrap.

## Timing
- Stall, flush and forward outputs are combinational from the current inputs and state, with zero latency.
- FSM, waitCnt, memTimeout and the counters are registered and update on the rising clk edge.
- memTimeout rises on the edge that completes the MAX_MEM_WAIT-th consecutive memStall cycle. The cycle after that edge is the first cycle with TRAP behaviour.
- memReadyM=1 in any memStall cycle ends that stall in the same cycle (stallF..M=0), and the FSM returns to RUN on the next edge.
- While rst=1:
  - all stall and flush outputs are 0;
  - forwardAE and forwardBE are 00;
  - state←RUN, waitCnt←0, memTimeout←0, and both counters←0 on the edge.
- Reset asserted mid-wait or in TRAP returns to RUN on the next edge.
- Simultaneous memStall and redirect: memStall wins, redirect is not counted, and PCSrcE is re-evaluated once the stall releases.

## Structure
- Shared package riscv_pipe_pkg holds:
  - FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10;
  - RESULT_SRC_LOAD=2'b01, PCSRC_SEQ=2'b00;
  - the FSM state enum.
- One sub-module, sat_counter, parametrised by width, with synchronous reset and inc/saturate logic. It is instantiated twice.
- The priority mux and FSM live in pipeline_hazard_ctrl.

## Test plan
- Forwarding: Rs1E=5, RdM=5, regWriteM=1, RdW=5, regWriteW=1 → forwardAE=10. Set regWriteM=0 → forwardAE=01. Set Rs1E=RdM=RdW=0 → forwardAE=00.
- Load-use: resultSrcE=01, RdE=7, Rs2D=7 → stallF=stallD=flushE=1, stallCount increments by 1. Add PCSrcE=01 → only flushD=flushE=1, and redirectCount increments by 1.
- Memory wait: memReqM=1, memReadyM=0 for 3 cycles, then 1 → stallF..M=1 and flushW=1 for 3 cycles, released in the 4th; memTimeout=0; stallCount increments by 3.
- Timeout, MAX_MEM_WAIT=4: hold memReqM=1, memReadyM=0 → memTimeout=1 after 4 edges. It stays 1 even when memReadyM=1. It clears after 1 cycle of rst, with counters reading 0.
- exBusyE=1 for 2 cycles with PCSrcE=10 → stallF/D/E=1, flushM=1, flushD=flushE=0, redirectCount unchanged. Next cycle exBusyE=0 → flushD=flushE=1.
- Saturation, CNT_W=3: 9 consecutive load-use stall cycles → stallCount=7, holding at 7.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline constants and the hazard controller FSM state type.
package riscv_pipe_pkg;

  localparam logic [1:0] FWD_RF          = 2'b00;
  localparam logic [1:0] FWD_W           = 2'b01;
  localparam logic [1:0] FWD_M           = 2'b10;
  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;
  localparam logic [1:0] PCSRC_SEQ       = 2'b00;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    TRAP     = 2'd2
  } hazardState_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline register/handshake status in, enables/clears out.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
);

  logic [REG_ADDR_W-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic                  regWriteM, regWriteW;
  logic [1:0]            resultSrcE, PCSrcE;
  logic                  memReqM, memReadyM, exBusyE;

  logic                  stallF, stallD, stallE, stallM;
  logic                  flushD, flushE, flushM, flushW;
  logic [1:0]            forwardAE, forwardBE;
  logic                  memTimeout;
  logic [CNT_W-1:0]      stallCount, redirectCount;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output regWriteM, regWriteW, resultSrcE, PCSrcE,
    output memReqM, memReadyM, exBusyE,
    input  stallF, stallD, stallE, stallM,
    input  flushD, flushE, flushM, flushW,
    input  forwardAE, forwardBE, memTimeout, stallCount, redirectCount
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  regWriteM, regWriteW, resultSrcE, PCSrcE,
    input  memReqM, memReadyM, exBusyE,
    output stallF, stallD, stallE, stallM,
    output flushD, flushE, flushM, flushW,
    output forwardAE, forwardBE, memTimeout, stallCount, redirectCount
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] countReg;

  always_ff @(posedge clk) begin
    if (rst) begin
      countReg <= '0;
    end else if (inc && (countReg != '1)) begin
      countReg <= countReg + 1'b1;
    end
  end

  assign count = countReg;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush arbitration, E-stage forwarding and memory-timeout FSM for the 5-stage pipeline.
module pipeline_hazard_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int REG_ADDR_W   = 5,
  parameter int CNT_W        = 32,
  parameter int MAX_MEM_WAIT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  pipeline_hazard_ctrl_if.slave  hz
);

  localparam int WAIT_W = $clog2(MAX_MEM_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_MEM_WAIT);

  hazardState_t      stateReg, stateNext;
  logic [WAIT_W-1:0] waitCntReg, waitCntNext;

  logic memStall, redirect, loadUse;
  logic stallF, stallD, stallE, stallM;
  logic flushD, flushE, flushM, flushW;
  logic redirectHit;

  logic [REG_ADDR_W-1:0] rsE [2];
  logic [1:0]            fwdSel [2];

  assign rsE[0] = hz.Rs1E;
  assign rsE[1] = hz.Rs2E;

  // M has the younger result, so it beats W when both match.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      always_comb begin
        fwdSel[gi] = FWD_RF;
        if (!rst) begin
          if (hz.regWriteM && (hz.RdM != '0) && (hz.RdM == rsE[gi])) begin
            fwdSel[gi] = FWD_M;
          end else if (hz.regWriteW && (hz.RdW != '0) && (hz.RdW == rsE[gi])) begin
            fwdSel[gi] = FWD_W;
          end
        end
      end
    end
  endgenerate

  assign hz.forwardAE = fwdSel[0];
  assign hz.forwardBE = fwdSel[1];

  assign memStall = hz.memReqM && !hz.memReadyM;
  assign redirect = (hz.PCSrcE != PCSRC_SEQ);
  assign loadUse  = (hz.resultSrcE == RESULT_SRC_LOAD) && (hz.RdE != '0) &&
                    ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

  always_comb begin
    stallF      = 1'b0;
    stallD      = 1'b0;
    stallE      = 1'b0;
    stallM      = 1'b0;
    flushD      = 1'b0;
    flushE      = 1'b0;
    flushM      = 1'b0;
    flushW      = 1'b0;
    redirectHit = 1'b0;
    if (rst) begin
      redirectHit = 1'b0;
    end else if ((stateReg == TRAP) || memStall) begin
      // Freeze everything up to M and bubble into W.
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      stallM = 1'b1;
      flushW = 1'b1;
    end else if (hz.exBusyE) begin
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      flushM = 1'b1;
    end else if (redirect) begin
      flushD      = 1'b1;
      flushE      = 1'b1;
      redirectHit = 1'b1;
    end else if (loadUse) begin
      stallF = 1'b1;
      stallD = 1'b1;
      flushE = 1'b1;
    end
  end

  assign hz.stallF = stallF;
  assign hz.stallD = stallD;
  assign hz.stallE = stallE;
  assign hz.stallM = stallM;
  assign hz.flushD = flushD;
  assign hz.flushE = flushE;
  assign hz.flushM = flushM;
  assign hz.flushW = flushW;

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg   <= RUN;
      waitCntReg <= '0;
    end else begin
      stateReg   <= stateNext;
      waitCntReg <= waitCntNext;
    end
  end

  always_comb begin
    stateNext   = stateReg;
    waitCntNext = waitCntReg;
    case (stateReg)
      RUN: begin
        if (memStall) begin
          waitCntNext = WAIT_W'(1);
          stateNext   = (MAX_MEM_WAIT == 1) ? TRAP : MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (!memStall) begin
          waitCntNext = '0;
          stateNext   = RUN;
        end else begin
          waitCntNext = waitCntReg + 1'b1;
          if ((waitCntReg + 1'b1) == WAIT_LIMIT) begin
            stateNext = TRAP;
          end
        end
      end
      TRAP: begin
        stateNext = TRAP;
      end
      default: begin
        stateNext   = RUN;
        waitCntNext = '0;
      end
    endcase
  end

  assign hz.memTimeout = (stateReg == TRAP);

  sat_counter #(.WIDTH(CNT_W)) u_stallCounter (
    .clk   (clk),
    .rst   (rst),
    .inc   (stallF),
    .count (hz.stallCount)
  );

  sat_counter #(.WIDTH(CNT_W)) u_redirectCounter (
    .clk   (clk),
    .rst   (rst),
    .inc   (redirectHit),
    .count (hz.redirectCount)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with a short timeout and 3-bit counters.
module tb_pipeline_hazard_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  pipeline_hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(3)) hzIf ();

  pipeline_hazard_ctrl #(
    .REG_ADDR_W   (5),
    .CNT_W        (3),
    .MAX_MEM_WAIT (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hzIf.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearIn();
    hzIf.Rs1D = '0; hzIf.Rs2D = '0; hzIf.Rs1E = '0; hzIf.Rs2E = '0;
    hzIf.RdE = '0; hzIf.RdM = '0; hzIf.RdW = '0;
    hzIf.regWriteM = 1'b0; hzIf.regWriteW = 1'b0;
    hzIf.resultSrcE = 2'b00; hzIf.PCSrcE = 2'b00;
    hzIf.memReqM = 1'b0; hzIf.memReadyM = 1'b0; hzIf.exBusyE = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clearIn();
    rst = 1'b1;

    // Reset gating: hazards and forwards present but masked
    hzIf.resultSrcE = 2'b01; hzIf.RdE = 5'd7; hzIf.Rs2D = 5'd7;
    hzIf.Rs1E = 5'd5; hzIf.RdM = 5'd5; hzIf.regWriteM = 1'b1;
    #1;
    chk("rst_stallF", 32'(hzIf.stallF), 0);
    chk("rst_flushE", 32'(hzIf.flushE), 0);
    chk("rst_fwdA", 32'(hzIf.forwardAE), 0);
    step();
    rst = 1'b0;
    clearIn();
    #1;
    chk("rst_stallCount", 32'(hzIf.stallCount), 0);
    chk("rst_redirectCount", 32'(hzIf.redirectCount), 0);
    chk("rst_memTimeout", 32'(hzIf.memTimeout), 0);

    // Forwarding
    hzIf.Rs1E = 5'd5; hzIf.RdM = 5'd5; hzIf.regWriteM = 1'b1;
    hzIf.RdW = 5'd5; hzIf.regWriteW = 1'b1;
    #1; chk("fwdA_M", 32'(hzIf.forwardAE), 2);
    hzIf.regWriteM = 1'b0;
    #1; chk("fwdA_W", 32'(hzIf.forwardAE), 1);
    hzIf.regWriteM = 1'b1; hzIf.Rs1E = 5'd0; hzIf.RdM = 5'd0; hzIf.RdW = 5'd0;
    #1; chk("fwdA_x0", 32'(hzIf.forwardAE), 0);
    hzIf.Rs2E = 5'd3; hzIf.RdW = 5'd3; hzIf.RdM = 5'd4;
    #1; chk("fwdB_W", 32'(hzIf.forwardBE), 1);
    chk("fwd_nostall", 32'(hzIf.stallF), 0);
    clearIn();

    // Load-use, then redirect overriding it
    hzIf.resultSrcE = 2'b01; hzIf.RdE = 5'd7; hzIf.Rs2D = 5'd7;
    #1;
    chk("lu_stallF", 32'(hzIf.stallF), 1);
    chk("lu_stallD", 32'(hzIf.stallD), 1);
    chk("lu_flushE", 32'(hzIf.flushE), 1);
    chk("lu_stallE", 32'(hzIf.stallE), 0);
    chk("lu_flushD", 32'(hzIf.flushD), 0);
    step();
    chk("lu_stallCount", 32'(hzIf.stallCount), 1);
    hzIf.PCSrcE = 2'b01;
    #1;
    chk("redir_stallF", 32'(hzIf.stallF), 0);
    chk("redir_flushD", 32'(hzIf.flushD), 1);
    chk("redir_flushE", 32'(hzIf.flushE), 1);
    step();
    chk("redir_count", 32'(hzIf.redirectCount), 1);
    chk("redir_stallCount", 32'(hzIf.stallCount), 1);
    clearIn();
    hzIf.resultSrcE = 2'b01; hzIf.RdE = 5'd0; hzIf.Rs1D = 5'd0;
    #1; chk("lu_x0", 32'(hzIf.stallF), 0);
    clearIn();

    // Memory wait of 3 cycles
    doReset();
    hzIf.memReqM = 1'b1; hzIf.memReadyM = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("mw_stallM_%0d", i), 32'(hzIf.stallM), 1);
      chk($sformatf("mw_flushW_%0d", i), 32'(hzIf.flushW), 1);
      step();
    end
    hzIf.memReadyM = 1'b1;
    #1;
    chk("mw_rel_stallF", 32'(hzIf.stallF), 0);
    chk("mw_rel_stallM", 32'(hzIf.stallM), 0);
    chk("mw_rel_flushW", 32'(hzIf.flushW), 0);
    chk("mw_memTimeout", 32'(hzIf.memTimeout), 0);
    chk("mw_stallCount", 32'(hzIf.stallCount), 3);
    step();
    chk("mw_stallCount_hold", 32'(hzIf.stallCount), 3);

    // memStall beats redirect; redirect taken once released
    hzIf.memReadyM = 1'b0; hzIf.PCSrcE = 2'b01;
    #1;
    chk("msr_flushD", 32'(hzIf.flushD), 0);
    chk("msr_stallF", 32'(hzIf.stallF), 1);
    step();
    chk("msr_redirectCount", 32'(hzIf.redirectCount), 0);
    hzIf.memReadyM = 1'b1;
    #1; chk("msr_rel_flushD", 32'(hzIf.flushD), 1);
    step();
    chk("msr_rel_redirectCount", 32'(hzIf.redirectCount), 1);
    chk("msr_stallCount", 32'(hzIf.stallCount), 4);
    clearIn();

    // Timeout after 4 not-ready cycles
    doReset();
    hzIf.memReqM = 1'b1; hzIf.memReadyM = 1'b0;
    step(); step(); step();
    chk("to_before", 32'(hzIf.memTimeout), 0);
    step();
    chk("to_rise", 32'(hzIf.memTimeout), 1);
    hzIf.memReadyM = 1'b1;
    #1;
    chk("to_trap_stallF", 32'(hzIf.stallF), 1);
    chk("to_trap_flushW", 32'(hzIf.flushW), 1);
    chk("to_trap_flushD", 32'(hzIf.flushD), 0);
    step();
    chk("to_sticky", 32'(hzIf.memTimeout), 1);
    chk("to_stallCount", 32'(hzIf.stallCount), 5);
    rst = 1'b1;
    #1; chk("to_rst_stallF", 32'(hzIf.stallF), 0);
    step();
    rst = 1'b0;
    #1;
    chk("to_clear", 32'(hzIf.memTimeout), 0);
    chk("to_clr_stallCount", 32'(hzIf.stallCount), 0);
    chk("to_clr_redirectCount", 32'(hzIf.redirectCount), 0);
    chk("to_clr_stallF", 32'(hzIf.stallF), 0);
    clearIn();

    // Execute busy masks redirect
    hzIf.exBusyE = 1'b1; hzIf.PCSrcE = 2'b10;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk($sformatf("ex_stallE_%0d", i), 32'(hzIf.stallE), 1);
      chk($sformatf("ex_flushM_%0d", i), 32'(hzIf.flushM), 1);
      chk($sformatf("ex_flushD_%0d", i), 32'(hzIf.flushD), 0);
      chk($sformatf("ex_stallM_%0d", i), 32'(hzIf.stallM), 0);
      step();
    end
    chk("ex_redirectCount", 32'(hzIf.redirectCount), 0);
    hzIf.exBusyE = 1'b0;
    #1;
    chk("ex_rel_flushD", 32'(hzIf.flushD), 1);
    chk("ex_rel_flushE", 32'(hzIf.flushE), 1);
    chk("ex_rel_stallF", 32'(hzIf.stallF), 0);
    step();
    chk("ex_rel_redirectCount", 32'(hzIf.redirectCount), 1);
    clearIn();

    // Saturation of the 3-bit stall counter
    doReset();
    hzIf.resultSrcE = 2'b01; hzIf.RdE = 5'd9; hzIf.Rs1D = 5'd9;
    for (int i = 0; i < 6; i++) step();
    chk("sat_6", 32'(hzIf.stallCount), 6);
    step();
    chk("sat_7", 32'(hzIf.stallCount), 7);
    step(); step();
    chk("sat_9", 32'(hzIf.stallCount), 7);
    step();
    chk("sat_hold", 32'(hzIf.stallCount), 7);
    clearIn();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
